// File: rtl/nexttime_monitor_if.sv
// Handshake bundle between a property-side driver and the nexttime monitor:
// tick/start/operand/end-of-trace in, verdict counts and pending level out.
interface nexttime_monitor_if #(
    parameter int CNT_W = 8
) ();
    logic             tick;
    logic             start;
    logic             a;
    logic             eot;
    logic [CNT_W-1:0] pass_num;
    logic [CNT_W-1:0] fail_num;
    logic [CNT_W-1:0] pending;
    logic             ovf;

    modport master (
        output tick, start, a, eot,
        input  pass_num, fail_num, pending, ovf
    );

    modport slave (
        input  tick, start, a, eot,
        output pass_num, fail_num, pending, ovf
    );
endinterface

// File: rtl/nexttime_monitor.sv
// Runtime monitor for nexttime[N] a / always a / s_eventually a, emitting per-cycle
// pass/fail counts, the unresolved-attempt level and a sticky saturation flag.
module nexttime_monitor #(
    parameter int N      = 1,
    parameter int MODE   = 0,
    parameter int STRONG = 0,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    nexttime_monitor_if.slave  bus
);
    // Sums are formed with headroom so saturation can be detected before clamping.
    localparam int W = CNT_W + 6;
    localparam logic [W-1:0] MAX = {{6{1'b0}}, {CNT_W{1'b1}}};

    logic [N-1:0]     r_pipe;
    logic [CNT_W-1:0] r_act;
    logic [CNT_W-1:0] r_wait;
    logic [CNT_W-1:0] r_pass;
    logic [CNT_W-1:0] r_fail;
    logic [CNT_W-1:0] r_pending;
    logic             r_ovf;

    logic [N-1:0]     w_pipe;
    logic             w_mat;
    logic [W-1:0]     w_act;
    logic [W-1:0]     w_wait;
    logic [W-1:0]     w_pass;
    logic [W-1:0]     w_fail;
    logic [W-1:0]     w_pend;
    logic             w_ovfSet;

    function automatic logic [W-1:0] popcnt(input logic [N-1:0] v);
        logic [W-1:0] c;
        c = '0;
        for (int k = 0; k < N; k++) c = c + W'(v[k]);
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] sat(input logic [W-1:0] v);
        return (v > MAX) ? {CNT_W{1'b1}} : v[CNT_W-1:0];
    endfunction

    always_comb begin
        w_pipe   = r_pipe;
        w_mat    = r_pipe[N-1];
        w_act    = W'(r_act);
        w_wait   = W'(r_wait);
        w_pass   = '0;
        w_fail   = '0;
        w_pend   = '0;
        w_ovfSet = 1'b0;

        if (bus.tick) begin
            w_pipe = (r_pipe << 1) | N'(bus.start);
            if (MODE == 0) begin
                if (w_mat) begin
                    if (bus.a) w_pass = W'(1);
                    else       w_fail = W'(1);
                end
            end else if (MODE == 1) begin
                // The maturing attempt is already part of the set when a is checked.
                w_act = w_act + W'(w_mat);
                if (!bus.a) begin
                    w_fail = w_act;
                    w_act  = '0;
                end
            end else begin
                if (w_mat && bus.a) w_pass = W'(1);
                if (bus.a) begin
                    w_pass = w_pass + w_wait;
                    w_wait = '0;
                end else begin
                    w_wait = w_wait + W'(w_mat);
                end
            end
        end

        // End of trace resolves whatever survived the tick evaluation above.
        if (bus.eot) begin
            if (STRONG != 0) w_fail = w_fail + popcnt(w_pipe);
            else             w_pass = w_pass + popcnt(w_pipe);
            if (MODE == 1) w_pass = w_pass + w_act;
            if (MODE == 2) w_fail = w_fail + w_wait;
            w_pipe = '0;
            w_act  = '0;
            w_wait = '0;
        end

        w_pend   = popcnt(w_pipe) + W'(sat(w_act)) + W'(sat(w_wait));
        w_ovfSet = (w_pass > MAX) || (w_fail > MAX) || (w_pend > MAX) ||
                   (w_act > MAX) || (w_wait > MAX);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pipe    <= '0;
            r_act     <= '0;
            r_wait    <= '0;
            r_pass    <= '0;
            r_fail    <= '0;
            r_pending <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_pipe    <= w_pipe;
            r_act     <= sat(w_act);
            r_wait    <= sat(w_wait);
            r_pass    <= sat(w_pass);
            r_fail    <= sat(w_fail);
            r_pending <= sat(w_pend);
            r_ovf     <= r_ovf | w_ovfSet;
        end
    end

    assign bus.pass_num = r_pass;
    assign bus.fail_num = r_fail;
    assign bus.pending  = r_pending;
    assign bus.ovf      = r_ovf;
endmodule

// File: tb/tb_nexttime_monitor.sv
// Five monitor configurations share one directed stimulus; a queue-based model of
// attempt lifetimes predicts every output each cycle, plus literal spot checks.
module tb_nexttime_monitor;
    logic clk;
    logic rst_n;
    logic tick, start, a, eot;
    int   total;
    int   bad;
    bit   checking;

    localparam int PM [5] = '{0, 0, 1, 2, 2};
    localparam int PN [5] = '{2, 3, 1, 1, 1};
    localparam int PS [5] = '{0, 1, 0, 1, 0};
    localparam int PC [5] = '{8, 8, 8, 8, 2};

    nexttime_monitor_if #(.CNT_W(8)) if0 ();
    nexttime_monitor_if #(.CNT_W(8)) if1 ();
    nexttime_monitor_if #(.CNT_W(8)) if2 ();
    nexttime_monitor_if #(.CNT_W(8)) if3 ();
    nexttime_monitor_if #(.CNT_W(2)) if4 ();

    assign if0.tick = tick; assign if0.start = start; assign if0.a = a; assign if0.eot = eot;
    assign if1.tick = tick; assign if1.start = start; assign if1.a = a; assign if1.eot = eot;
    assign if2.tick = tick; assign if2.start = start; assign if2.a = a; assign if2.eot = eot;
    assign if3.tick = tick; assign if3.start = start; assign if3.a = a; assign if3.eot = eot;
    assign if4.tick = tick; assign if4.start = start; assign if4.a = a; assign if4.eot = eot;

    nexttime_monitor #(.N(2), .MODE(0), .STRONG(0), .CNT_W(8)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
    nexttime_monitor #(.N(3), .MODE(0), .STRONG(1), .CNT_W(8)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
    nexttime_monitor #(.N(1), .MODE(1), .STRONG(0), .CNT_W(8)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));
    nexttime_monitor #(.N(1), .MODE(2), .STRONG(1), .CNT_W(8)) u3 (.clk(clk), .rst_n(rst_n), .bus(if3.slave));
    nexttime_monitor #(.N(1), .MODE(2), .STRONG(0), .CNT_W(2)) u4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: each outstanding attempt is its remaining tick count.
    int mQ [5][$];
    int mAct [5];
    int mWait [5];
    int eP [5];
    int eF [5];
    int ePd [5];
    bit eO [5];

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    function automatic int clampTo(input int v, input int mx, inout bit o);
        if (v > mx) begin
            o = 1'b1;
            return mx;
        end
        return v;
    endfunction

    task automatic modelStep(input int i);
        int mx, p, f, m, n;
        int keep[$];
        mx = (1 << PC[i]) - 1;
        p = 0; f = 0; m = 0;
        if (!rst_n) begin
            mQ[i].delete();
            mAct[i] = 0; mWait[i] = 0;
            eP[i] = 0; eF[i] = 0; ePd[i] = 0; eO[i] = 1'b0;
            return;
        end
        if (tick) begin
            foreach (mQ[i][k]) begin
                if (mQ[i][k] == 1) m++;
                else keep.push_back(mQ[i][k] - 1);
            end
            mQ[i] = keep;
            if (start) mQ[i].push_back(PN[i]);
            if (PM[i] == 0) begin
                if (a) p += m; else f += m;
            end else if (PM[i] == 1) begin
                mAct[i] += m;
                if (!a) begin f += mAct[i]; mAct[i] = 0; end
            end else begin
                if (a) begin p += m + mWait[i]; mWait[i] = 0; end
                else mWait[i] += m;
            end
        end
        if (eot) begin
            n = mQ[i].size();
            if (PS[i] != 0) f += n; else p += n;
            if (PM[i] == 1) p += mAct[i];
            if (PM[i] == 2) f += mWait[i];
            mQ[i].delete();
            mAct[i] = 0; mWait[i] = 0;
        end
        mAct[i]  = clampTo(mAct[i], mx, eO[i]);
        mWait[i] = clampTo(mWait[i], mx, eO[i]);
        eP[i]    = clampTo(p, mx, eO[i]);
        eF[i]    = clampTo(f, mx, eO[i]);
        ePd[i]   = clampTo(mQ[i].size() + mAct[i] + mWait[i], mx, eO[i]);
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 5; i++) modelStep(i);
    end

    task automatic cmpInst(input int i, input int p, input int f, input int pd, input int o);
        check($sformatf("u%0d.pass_num", i), p, eP[i]);
        check($sformatf("u%0d.fail_num", i), f, eF[i]);
        check($sformatf("u%0d.pending", i), pd, ePd[i]);
        check($sformatf("u%0d.ovf", i), o, int'(eO[i]));
    endtask

    always @(negedge clk) begin
        if (checking) begin
            cmpInst(0, int'(if0.pass_num), int'(if0.fail_num), int'(if0.pending), int'(if0.ovf));
            cmpInst(1, int'(if1.pass_num), int'(if1.fail_num), int'(if1.pending), int'(if1.ovf));
            cmpInst(2, int'(if2.pass_num), int'(if2.fail_num), int'(if2.pending), int'(if2.ovf));
            cmpInst(3, int'(if3.pass_num), int'(if3.fail_num), int'(if3.pending), int'(if3.ovf));
            cmpInst(4, int'(if4.pass_num), int'(if4.fail_num), int'(if4.pending), int'(if4.ovf));
        end
    end

    task automatic applyStimulus(input logic r, input logic t, input logic s, input logic aa, input logic e);
        rst_n = r; tick = t; start = s; a = aa; eot = e;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string nm, input int act, input int exp);
        check(nm, act, exp);
    endtask

    initial begin
        int expP [6];
        int expF [6];
        logic sv [6];
        logic av [6];
        total = 0; bad = 0; checking = 1'b0;
        rst_n = 1'b0; tick = 1'b0; start = 1'b0; a = 1'b0; eot = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 1);
        checking = 1'b1;
        checkOutput("reset_pass", int'(if0.pass_num), 0);
        checkOutput("reset_pending", int'(if2.pending), 0);
        checkOutput("reset_ovf", int'(if4.ovf), 0);

        // Single attempt, N=2, a=1 on the maturing tick
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("m0_inflight_pending", int'(if0.pending), 1);
        applyStimulus(1, 1, 0, 1, 0);
        checkOutput("m0_single_pass", int'(if0.pass_num), 1);
        checkOutput("m0_single_fail", int'(if0.fail_num), 0);
        checkOutput("m0_single_pending", int'(if0.pending), 0);

        // Back-to-back starts, then the same with a 3-cycle tick gap
        sv   = '{1, 1, 1, 1, 0, 0};
        av   = '{0, 0, 1, 1, 0, 1};
        expP = '{0, 0, 1, 1, 0, 1};
        expF = '{0, 0, 0, 0, 1, 0};
        applyStimulus(0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1, 1, sv[k], av[k], 0);
            checkOutput($sformatf("m0_stream_pass%0d", k), int'(if0.pass_num), expP[k]);
            checkOutput($sformatf("m0_stream_fail%0d", k), int'(if0.fail_num), expF[k]);
        end
        applyStimulus(0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin
                for (int g = 0; g < 3; g++) begin
                    applyStimulus(1, 0, 1, 0, 0);
                    checkOutput("m0_gap_fail", int'(if0.fail_num), 0);
                end
            end
            applyStimulus(1, 1, sv[k], av[k], 0);
            checkOutput($sformatf("m0_gap_pass%0d", k), int'(if0.pass_num), expP[k]);
            checkOutput($sformatf("m0_gap_fail%0d", k), int'(if0.fail_num), expF[k]);
        end

        // eot before maturity: weak passes, strong fails
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("eot_weak_pass", int'(if0.pass_num), 1);
        checkOutput("eot_strong_fail", int'(if1.fail_num), 1);
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("eot_after_pending", int'(if1.pending), 0);

        // MODE1: two attempts held until a drops, then until eot
        for (int rep = 0; rep < 2; rep++) begin
            applyStimulus(0, 0, 0, 0, 0);
            for (int k = 0; k < 6; k++)
                applyStimulus(1, 1, logic'(k < 2), 1, logic'(rep == 1 && k == 5));
            if (rep == 0) begin
                checkOutput("m1_held_pending", int'(if2.pending), 2);
                applyStimulus(1, 1, 0, 0, 0);
                checkOutput("m1_drop_fail", int'(if2.fail_num), 2);
            end else begin
                checkOutput("m1_eot_pass", int'(if2.pass_num), 2);
            end
        end

        // MODE2: three waiting attempts released together, or failed at eot
        applyStimulus(0, 0, 0, 0, 0);
        for (int k = 0; k < 8; k++) applyStimulus(1, 1, logic'(k < 3), 0, 0);
        checkOutput("m2_wait_pending", int'(if3.pending), 3);
        applyStimulus(1, 1, 0, 1, 0);
        checkOutput("m2_release_pass", int'(if3.pass_num), 3);
        applyStimulus(0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) applyStimulus(1, 1, logic'(k < 3), 0, 0);
        applyStimulus(1, 0, 0, 0, 1);
        checkOutput("m2_eot_fail", int'(if3.fail_num), 3);

        // Saturation with CNT_W=2, then reset mid-run
        applyStimulus(0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) applyStimulus(1, 1, 1, 0, 0);
        checkOutput("sat_pending", int'(if4.pending), 3);
        checkOutput("sat_ovf", int'(if4.ovf), 1);
        applyStimulus(0, 1, 1, 1, 1);
        checkOutput("rst_pass", int'(if4.pass_num), 0);
        checkOutput("rst_fail", int'(if4.fail_num), 0);
        checkOutput("rst_pending", int'(if4.pending), 0);
        checkOutput("rst_ovf", int'(if4.ovf), 0);
        applyStimulus(1, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0);

        checking = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
